fetch_stage: RTL and testbench

F-stage front end of the five-stage MIPS pipeline: PC register, next-PC selection and the F/D pipeline register.
- Consumes the Stall produced by the hazard unit: a stall freezes PC and F/D.
- Consumes D-stage control-transfer info: redirects fetch using one architectural delay slot.
- Drives the testbench-owned instruction memory address and captures its returned word into F/D.

---
 rtl/fetch_stage_pkg.sv | 23 ++
 rtl/fetch_stage_npc.sv | 35 +++
 rtl/fetch_stage.sv | 55 +++++
 tb/tb_fetch_stage.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the MIPS fetch stage: next-PC selector codes,
// reset values and the F/D register layout.
package fetch_stage_pkg;

  localparam logic [2:0] NPC_PC4 = 3'd0;
  localparam logic [2:0] NPC_BEQ = 3'd1;
  localparam logic [2:0] NPC_J   = 3'd2;
  localparam logic [2:0] NPC_JR  = 3'd3;

  localparam logic [31:0] PC_RESET_DEFAULT  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fd_reg_t;

  // Word-offset branch displacement: sign-extended imm16 scaled by 4.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_npc.sv
// Combinational next-PC unit. Control transfers resolve against the D-stage
// instruction, so the F-stage instruction is always the architectural delay slot.
module fetch_stage_npc
  import fetch_stage_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] d_pc,
  input  logic [25:0] d_instr_low,
  input  logic [2:0]  d_npc_sel,
  input  logic        d_cmp,
  input  logic [31:0] d_rs_val,
  output logic [31:0] npc
);

  logic [31:0] pc_plus4;
  logic [31:0] d_pc_plus4;
  logic [31:0] br_target;
  logic [31:0] j_target;

  assign pc_plus4   = pc + 32'd4;
  assign d_pc_plus4 = d_pc + 32'd4;
  assign br_target  = d_pc_plus4 + branch_offset(d_instr_low[15:0]);
  assign j_target   = {d_pc_plus4[31:28], d_instr_low, 2'b00};

  always_comb begin
    npc = pc_plus4;
    case (d_npc_sel)
      NPC_BEQ: npc = d_cmp ? br_target : pc_plus4;
      NPC_J:   npc = j_target;
      NPC_JR:  npc = d_rs_val;
      default: npc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// F-stage front end: PC register, next-PC selection and the F/D pipeline
// register. A stall freezes both registers; reset overrides stall.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET  = PC_RESET_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  input  logic        Stall,
  input  logic [2:0]  D_npc_sel,
  input  logic        D_cmp,
  input  logic [31:0] D_rs_val,
  output logic [31:0] D_Instr,
  output logic [31:0] D_pc,
  output logic [31:0] D_pc8
);

  logic [31:0] pc_reg;
  logic [31:0] pc_next;
  fd_reg_t     fd_reg;

  fetch_stage_npc u_npc (
    .pc          (pc_reg),
    .d_pc        (fd_reg.pc),
    .d_instr_low (fd_reg.instr[25:0]),
    .d_npc_sel   (D_npc_sel),
    .d_cmp       (D_cmp),
    .d_rs_val    (D_rs_val),
    .npc         (pc_next)
  );

  // A redirect held off by Stall is simply re-evaluated once the stall drops,
  // so forwarded operands current at release time are the ones used.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg       <= PC_RESET;
      fd_reg.instr <= NOP_INSTR;
      fd_reg.pc    <= PC_RESET;
    end else if (!Stall) begin
      pc_reg       <= pc_next;
      fd_reg.instr <= i_inst_rdata;
      fd_reg.pc    <= pc_reg;
    end
  end

  assign i_inst_addr = pc_reg;
  assign D_Instr     = fd_reg.instr;
  assign D_pc        = fd_reg.pc;
  assign D_pc8       = fd_reg.pc + 32'd8;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed pipeline scenarios followed by
// randomized control-transfer/stall/reset traffic against a behavioural model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_inst_addr;
  logic [31:0] i_inst_rdata;
  logic        Stall;
  logic [2:0]  D_npc_sel;
  logic        D_cmp;
  logic [31:0] D_rs_val;
  logic [31:0] D_Instr;
  logic [31:0] D_pc;
  logic [31:0] D_pc8;

  int checks = 0;
  int errors = 0;

  // Model state: fetch PC and the instruction/PC pair sitting in decode.
  logic [31:0] m_pc, m_dpc, m_dinstr;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .i_inst_addr  (i_inst_addr),
    .i_inst_rdata (i_inst_rdata),
    .Stall        (Stall),
    .D_npc_sel    (D_npc_sel),
    .D_cmp        (D_cmp),
    .D_rs_val     (D_rs_val),
    .D_Instr      (D_Instr),
    .D_pc         (D_pc),
    .D_pc8        (D_pc8)
  );

  // Instruction memory: a few planted control-transfer words, hashed data elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_3008: return {6'h04, 5'd1, 5'd2, 16'hFFFE};  // beq -2
      32'h0000_3010: return {6'h03, 26'h000_0C10};          // jal
      32'h0000_3020: return {6'h00, 5'd31, 15'd0, 6'h08};   // jr $31
      default:       return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endcase
  endfunction

  assign i_inst_rdata = mem_word(i_inst_addr);

  function automatic logic [31:0] model_npc(input logic [2:0] sel, input logic cmp,
                                            input logic [31:0] rs);
    int off;
    off = $signed(m_dinstr[15:0]);
    case (sel)
      3'd1:    return cmp ? m_dpc + 32'd4 + 32'(off * 4) : m_pc + 32'd4;
      3'd2:    return ((m_dpc + 32'd4) & 32'hF000_0000) | (32'(m_dinstr[25:0]) * 32'd4);
      3'd3:    return rs;
      default: return m_pc + 32'd4;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic cycle(input logic rst, input logic st, input logic [2:0] sel,
                       input logic cmp, input logic [31:0] rs);
    logic [31:0] nxt;
    reset = rst; Stall = st; D_npc_sel = sel; D_cmp = cmp; D_rs_val = rs;
    nxt = model_npc(sel, cmp, rs);
    if (rst) begin
      m_pc = 32'h0000_3000; m_dpc = 32'h0000_3000; m_dinstr = 32'h0;
    end else if (!st) begin
      m_dinstr = mem_word(m_pc); m_dpc = m_pc; m_pc = nxt;
    end
    @(posedge clk);
    #1;
    chk("addr", i_inst_addr, m_pc);
    chk("d_pc", D_pc, m_dpc);
    chk("d_instr", D_Instr, m_dinstr);
    chk("d_pc8", D_pc8, m_dpc + 32'd8);
    $display("t=%0t rst=%0b stall=%0b sel=%0d cmp=%0b rs=%h -> addr=%h d_pc=%h d_instr=%h",
             $time, rst, st, sel, cmp, rs, i_inst_addr, D_pc, D_Instr);
  endtask

  initial begin
    reset = 1'b1; Stall = 1'b0; D_npc_sel = 3'd0; D_cmp = 1'b0; D_rs_val = 32'h0;
    m_pc = 32'h0; m_dpc = 32'h0; m_dinstr = 32'h0;

    // Reset and straight-line fetch
    cycle(1, 0, 3'd0, 0, 0);
    chk("rst_addr", i_inst_addr, 32'h0000_3000);
    chk("rst_instr", D_Instr, 32'h0);
    cycle(0, 0, 3'd0, 0, 0);
    chk("seq_addr1", i_inst_addr, 32'h0000_3004);
    cycle(0, 0, 3'd0, 0, 0);
    cycle(0, 0, 3'd0, 0, 0);
    chk("seq_addr3", i_inst_addr, 32'h0000_300C);
    chk("seq_dpc3", D_pc, 32'h0000_3008);

    // beq taken: slot 0x300C moves into D, fetch goes to 0x3004
    cycle(0, 0, 3'd1, 1, 0);
    chk("beq_t_addr", i_inst_addr, 32'h0000_3004);
    chk("beq_t_slot", D_pc, 32'h0000_300C);

    // beq not taken: fetch continues sequentially
    cycle(0, 0, 3'd0, 0, 0);
    cycle(0, 0, 3'd0, 0, 0);
    cycle(0, 0, 3'd1, 0, 0);
    chk("beq_nt_addr", i_inst_addr, 32'h0000_3010);

    // jal at 0x3010
    cycle(0, 0, 3'd0, 0, 0);
    chk("jal_dpc8", D_pc8, 32'h0000_3018);
    cycle(0, 0, 3'd2, 0, 0);
    chk("jal_addr", i_inst_addr, 32'h0000_3040);
    chk("jal_slot", D_pc, 32'h0000_3014);

    // Reach jr at 0x3020, then stall two cycles while rs changes
    cycle(0, 0, 3'd0, 0, 0);
    cycle(0, 0, 3'd3, 0, 32'h0000_3020);
    cycle(0, 0, 3'd0, 0, 0);
    chk("jr_in_d", D_pc, 32'h0000_3020);
    cycle(0, 1, 3'd3, 0, 32'h0);
    chk("stall1_addr", i_inst_addr, 32'h0000_3024);
    cycle(0, 1, 3'd3, 0, 32'h0000_3100);
    chk("stall2_dpc", D_pc, 32'h0000_3020);
    cycle(0, 0, 3'd3, 0, 32'h0000_3100);
    chk("jr_addr", i_inst_addr, 32'h0000_3100);
    chk("jr_slot", D_pc, 32'h0000_3024);

    // Reset during stall with a redirect pending
    cycle(0, 1, 3'd3, 0, 32'h0000_5000);
    cycle(1, 1, 3'd3, 0, 32'h0000_5000);
    chk("rst_stall_addr", i_inst_addr, 32'h0000_3000);
    chk("rst_stall_instr", D_Instr, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            {$urandom_range(0, 32'h0000_FFFF), 2'b00} & 32'h0003_FFFC);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
